playfield_renderer: RTL and testbench

//  Pixel-colour stage between the game logic and the VGA pins. Holds a 10x20 board of 3-bit

---
 rtl/playfield_renderer_pkg.sv | 44 ++++
 rtl/playfield_renderer_if.sv | 21 ++
 rtl/playfield_renderer_board_ram.sv | 28 ++
 rtl/playfield_renderer.sv | 181 ++++++++++++++++++
 tb/tb_playfield_renderer.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/playfield_renderer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : playfield_renderer_pkg
//  Purpose  : VGA window constants, cell/colour types and palette shared by
//             the playfield renderer.
//  Revision : 1.0
// ============================================================================
package playfield_renderer_pkg;

    localparam int CELL_PX = 24;
    localparam int COLS    = 10;
    localparam int ROWS    = 20;
    localparam int CELLS   = COLS * ROWS;

    localparam logic [9:0] HBP   = 10'd144;
    localparam logic [9:0] HFP   = 10'd784;
    localparam logic [9:0] VBP   = 10'd31;
    localparam logic [9:0] VFP   = 10'd511;
    localparam logic [9:0] PF_X0 = 10'd344;
    localparam logic [9:0] PF_Y0 = 10'd31;
    localparam logic [9:0] PF_X1 = PF_X0 + 10'(COLS * CELL_PX);
    localparam logic [9:0] PF_Y1 = PF_Y0 + 10'(ROWS * CELL_PX);

    localparam logic [4:0] SUB_LAST  = 5'(CELL_PX - 1);
    localparam logic [7:0] ADDR_LAST = 8'(CELLS - 1);

    typedef logic [2:0] cell_t;
    typedef logic [7:0] rgb_t;

    localparam rgb_t BORDER_RGB = 8'b010_010_01;
    localparam rgb_t EDGE_RGB   = 8'hFF;

    // Index 0 is never displayed: code 0 is an empty (black) cell.
    localparam logic [7:0][7:0] PALETTE = {
        8'hF4, 8'h1F, 8'hE3, 8'hFC, 8'h03, 8'h1C, 8'hE0, 8'h00
    };

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/playfield_renderer_if.sv
`default_nettype none
// ============================================================================
//  Module   : playfield_renderer_if
//  Purpose  : Board-update bus between the game logic and the renderer.
//  Revision : 1.0
// ============================================================================
interface playfield_renderer_if;
    import playfield_renderer_pkg::*;

    logic       wr_en;
    logic [3:0] wr_col;
    logic [4:0] wr_row;
    cell_t      wr_color;
    logic       wr_ready;
    logic       clr;

    modport master (output wr_en, wr_col, wr_row, wr_color, clr, input wr_ready);
    modport slave  (input wr_en, wr_col, wr_row, wr_color, clr, output wr_ready);

endinterface
`default_nettype wire

// File: rtl/playfield_renderer_board_ram.sv
`default_nettype none
// ============================================================================
//  Module   : playfield_renderer_board_ram
//  Purpose  : 200 x 3-bit board store, one write port, one synchronous read.
//  Revision : 1.0
// ============================================================================
module playfield_renderer_board_ram
    import playfield_renderer_pkg::*;
(
    input  logic       i_pixclk,
    input  logic       i_we,
    input  logic [7:0] i_waddr,
    input  cell_t      i_wdata,
    input  logic [7:0] i_raddr,
    output cell_t      o_rdata
);

    cell_t r_mem [0:CELLS-1];

    always_ff @(posedge i_pixclk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule
`default_nettype wire

// File: rtl/playfield_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : playfield_renderer
//  Purpose  : Board store plus 2-stage pixel colour pipeline feeding the VGA
//             pins; board updates are taken only in vertical blank.
//  Revision : 1.0
// ============================================================================
module playfield_renderer
    import playfield_renderer_pkg::*;
(
    input  logic                 i_pixclk,
    input  logic                 i_rst,
    input  logic [9:0]           i_hcount,
    input  logic [9:0]           i_vcount,
    input  logic                 i_hsync,
    input  logic                 i_vsync,
    playfield_renderer_if.slave  wr_bus,
    output logic                 o_frame_start,
    output logic                 o_hsync,
    output logic                 o_vsync,
    output logic [2:0]           o_red,
    output logic [2:0]           o_green,
    output logic [1:0]           o_blue
);

    state_t     r_state, w_state_nx;
    logic [7:0] r_clr_addr, w_clr_addr_nx;
    logic       w_we;
    logic [7:0] w_waddr;
    cell_t      w_wdata;
    logic       w_wr_ready, w_wr_inrange;

    logic [4:0] r_sx, r_sy, w_sx, w_sy;
    logic [3:0] r_col, w_col;
    logic [7:0] r_row_base, w_row_base;
    logic       w_hstart, w_vis, w_in_pf;
    logic [7:0] w_raddr;
    logic       r_s1_vis, r_s1_pf, r_hs1, r_vs1;
    cell_t      w_cell;
    rgb_t       w_rgb;

    assign w_wr_ready = (r_state == ST_RUN) && ((i_vcount < VBP) || (i_vcount >= VFP));
    assign wr_bus.wr_ready = w_wr_ready;
    assign w_wr_inrange = (wr_bus.wr_col < 4'(COLS)) && (wr_bus.wr_row < 5'(ROWS));

    always_ff @(posedge i_pixclk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_clr_addr <= w_clr_addr_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_clr_addr_nx = r_clr_addr;
        w_we          = 1'b0;
        w_waddr       = r_clr_addr;
        w_wdata       = '0;
        case (r_state)
            ST_CLEAR: begin
                w_we = 1'b1;
                if (wr_bus.clr) begin
                    w_clr_addr_nx = '0;
                end else if (r_clr_addr == ADDR_LAST) begin
                    w_state_nx    = ST_RUN;
                    w_clr_addr_nx = '0;
                end else begin
                    w_clr_addr_nx = r_clr_addr + 8'd1;
                end
            end
            ST_RUN: begin
                if (wr_bus.clr) begin
                    w_state_nx    = ST_CLEAR;
                    w_clr_addr_nx = '0;
                end
                if (wr_bus.wr_en && w_wr_ready && w_wr_inrange) begin
                    w_we    = 1'b1;
                    w_waddr = {3'd0, wr_bus.wr_row} * 8'd10 + {4'd0, wr_bus.wr_col};
                    w_wdata = wr_bus.wr_color;
                end
            end
            default: begin
                w_state_nx    = ST_CLEAR;
                w_clr_addr_nx = '0;
            end
        endcase
    end

    // Cell position tracks the incoming raster incrementally: horizontal
    // counters restart at the play column, vertical ones step once per line.
    assign w_hstart = (i_hcount == PF_X0);

    always_comb begin
        w_sx       = r_sx + 5'd1;
        w_col      = r_col;
        w_sy       = r_sy;
        w_row_base = r_row_base;
        if (r_sx == SUB_LAST) begin
            w_sx  = '0;
            w_col = r_col + 4'd1;
        end
        if (w_hstart) begin
            w_sx  = '0;
            w_col = '0;
            if (i_vcount == PF_Y0) begin
                w_sy       = '0;
                w_row_base = '0;
            end else if (r_sy == SUB_LAST) begin
                w_sy       = '0;
                w_row_base = r_row_base + 8'd10;
            end else begin
                w_sy = r_sy + 5'd1;
            end
        end
    end

    assign w_vis   = (i_hcount >= HBP) && (i_hcount < HFP) && (i_vcount >= VBP) && (i_vcount < VFP);
    assign w_in_pf = (i_hcount >= PF_X0) && (i_hcount < PF_X1) && (i_vcount >= PF_Y0) && (i_vcount < PF_Y1);
    assign w_raddr = w_in_pf ? (w_row_base + {4'd0, w_col}) : 8'd0;

    playfield_renderer_board_ram u_board_ram (
        .i_pixclk (i_pixclk),
        .i_we     (w_we),
        .i_waddr  (w_waddr),
        .i_wdata  (w_wdata),
        .i_raddr  (w_raddr),
        .o_rdata  (w_cell)
    );

    always_comb begin
        w_rgb = '0;
        if (r_s1_vis) begin
            if (!r_s1_pf) begin
                w_rgb = BORDER_RGB;
            end else if ((r_state == ST_RUN) && (w_cell != '0)) begin
                if ((r_sx == '0) || (r_sx == SUB_LAST) || (r_sy == '0) || (r_sy == SUB_LAST)) begin
                    w_rgb = EDGE_RGB;
                end else begin
                    w_rgb = PALETTE[w_cell];
                end
            end
        end
    end

    always_ff @(posedge i_pixclk or posedge i_rst) begin
        if (i_rst) begin
            r_sx          <= '0;
            r_sy          <= '0;
            r_col         <= '0;
            r_row_base    <= '0;
            r_s1_vis      <= 1'b0;
            r_s1_pf       <= 1'b0;
            r_hs1         <= 1'b1;
            r_vs1         <= 1'b1;
            o_hsync       <= 1'b1;
            o_vsync       <= 1'b1;
            o_red         <= '0;
            o_green       <= '0;
            o_blue        <= '0;
            o_frame_start <= 1'b0;
        end else begin
            r_sx          <= w_sx;
            r_sy          <= w_sy;
            r_col         <= w_col;
            r_row_base    <= w_row_base;
            r_s1_vis      <= w_vis;
            r_s1_pf       <= w_in_pf;
            r_hs1         <= i_hsync;
            r_vs1         <= i_vsync;
            o_hsync       <= r_hs1;
            o_vsync       <= r_vs1;
            {o_red, o_green, o_blue} <= w_rgb;
            o_frame_start <= (i_hcount == 10'd0) && (i_vcount == VFP);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_playfield_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_playfield_renderer
//  Purpose  : Directed stimulus with a due-cycle scoreboard for the renderer.
//  Revision : 1.0
// ============================================================================
module tb_playfield_renderer;

    localparam int K_RDY = 0;
    localparam int K_RGB = 1;
    localparam int K_SYN = 2;
    localparam int K_FS  = 3;

    localparam logic [7:0] E_BLACK = 8'h00;
    localparam logic [7:0] E_GREY  = 8'h49;
    localparam logic [7:0] E_EDGE  = 8'hFF;
    localparam logic [7:0] E_PAL1  = 8'hE0;
    localparam logic [7:0] E_PAL3  = 8'h03;
    localparam logic [7:0] E_PAL7  = 8'hF4;

    typedef struct {
        int unsigned due;
        int          kind;
        logic [7:0]  exp;
        string       name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] hcount = '0;
    logic [9:0] vcount = '0;
    logic       hsync = 1'b1;
    logic       vsync = 1'b1;
    logic       fs, ohs, ovs;
    logic [2:0] red, green;
    logic [1:0] blue;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];

    playfield_renderer_if bus();

    playfield_renderer dut (
        .i_pixclk      (clk),
        .i_rst         (rst),
        .i_hcount      (hcount),
        .i_vcount      (vcount),
        .i_hsync       (hsync),
        .i_vsync       (vsync),
        .wr_bus        (bus),
        .o_frame_start (fs),
        .o_hsync       (ohs),
        .o_vsync       (ovs),
        .o_red         (red),
        .o_green       (green),
        .o_blue        (blue)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [7:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                case (sb[i].kind)
                    K_RDY:   act = {7'd0, bus.wr_ready};
                    K_RGB:   act = {red, green, blue};
                    K_SYN:   act = {6'd0, ohs, ovs};
                    default: act = {7'd0, fs};
                endcase
                checks++;
                if (act !== sb[i].exp) begin
                    errors++;
                    $display("FAIL %s at cycle %0d: got %h expected %h", sb[i].name, cyc, act, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: bench did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    task automatic expect_at(input int unsigned due, input int kind, input logic [7:0] e, input string nm);
        exp_t it;
        it.due  = due;
        it.kind = kind;
        it.exp  = e;
        it.name = nm;
        sb.push_back(it);
    endtask

    task automatic px(input int h, input int v);
        @(posedge clk);
        #1;
        hcount = 10'(h);
        vcount = 10'(v);
    endtask

    task automatic wr(input int col, input int row, input int code, input int v, input logic rdy, input string nm);
        @(posedge clk);
        #1;
        hcount       = 10'd0;
        vcount       = 10'(v);
        bus.wr_en    = 1'b1;
        bus.wr_col   = 4'(col);
        bus.wr_row   = 5'(row);
        bus.wr_color = 3'(code);
        expect_at(cyc, K_RDY, {7'd0, rdy}, nm);
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
    endtask

    // Replays the raster: one h=344 sample per play line, then the target line.
    task automatic render(input int ht, input int vt, input logic [7:0] e, input string nm);
        for (int v = 31; v < vt; v++) px(344, v);
        for (int h = 344; h <= ht; h++) px(h, vt);
        expect_at(cyc + 2, K_RGB, e, nm);
    endtask

    // Sweep starts in cycle c0 (address 0) and reaches RUN 200 cycles later.
    task automatic sweep_check(input int unsigned c0, input string nm);
        expect_at(cyc, K_RDY, 8'd0, nm);
        for (int k = 0; k < 400; k++) begin
            px(0, 0);
            if (cyc - c0 < 200) begin
                expect_at(cyc, K_RDY, 8'd0, nm);
            end else begin
                expect_at(cyc, K_RDY, 8'd1, {nm, "_done"});
                break;
            end
        end
    endtask

    initial begin
        int unsigned cc;
        logic [1:0]  pat [6];

        bus.wr_en    = 1'b0;
        bus.wr_col   = '0;
        bus.wr_row   = '0;
        bus.wr_color = '0;
        bus.clr      = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        expect_at(cyc, K_RGB, E_BLACK, "reset_rgb");
        expect_at(cyc, K_SYN, 8'd3, "reset_sync");
        expect_at(cyc, K_FS, 8'd0, "reset_frame_start");
        expect_at(cyc, K_RDY, 8'd0, "reset_ready");

        checks++;
        if ({ohs, ovs} !== 2'b11) begin
            errors++;
            $display("FAIL reset_sync_direct: got %b", {ohs, ovs});
        end
        checks++;
        if (fs !== 1'b0) begin
            errors++;
            $display("FAIL reset_fs_direct: got %b", fs);
        end
        checks++;
        if ({red, green, blue} !== E_BLACK) begin
            errors++;
            $display("FAIL reset_rgb_direct: got %h", {red, green, blue});
        end

        @(posedge clk);
        #1;
        rst = 1'b0;
        sweep_check(cyc, "init_sweep");

        checks++;
        if (bus.wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL init_sweep_ready_direct: got %b", bus.wr_ready);
        end

        px(0, 30);  expect_at(cyc, K_RDY, 8'd1, "ready_v30");
        px(0, 31);  expect_at(cyc, K_RDY, 8'd0, "ready_v31");
        px(0, 510); expect_at(cyc, K_RDY, 8'd0, "ready_v510");
        px(0, 511); expect_at(cyc, K_RDY, 8'd1, "ready_v511");
        px(0, 520); expect_at(cyc, K_RDY, 8'd1, "ready_v520");

        wr(0, 0, 1, 0, 1'b1, "wr_c0r0");
        render(344, 31, E_EDGE, "cell00_corner");
        render(356, 43, E_PAL1, "cell00_interior");

        px(200, 200); expect_at(cyc + 2, K_RGB, E_GREY,  "border_h200");
        px(50, 200);  expect_at(cyc + 2, K_RGB, E_BLACK, "offvis_h50");
        px(600, 200); expect_at(cyc + 2, K_RGB, E_GREY,  "border_h600");
        px(143, 200); expect_at(cyc + 2, K_RGB, E_BLACK, "offvis_h143");
        px(144, 200); expect_at(cyc + 2, K_RGB, E_GREY,  "border_h144");
        px(200, 511); expect_at(cyc + 2, K_RGB, E_BLACK, "offvis_v511");

        wr(5, 5, 3, 100, 1'b0, "wr_visible_rejected");
        render(476, 163, E_BLACK, "cell55_unchanged");
        wr(5, 5, 3, 515, 1'b1, "wr_vblank_accepted");
        render(476, 163, E_PAL3, "cell55_written");

        wr(10, 3, 5, 0, 1'b1, "wr_col10_ready");
        render(356, 139, E_BLACK, "col10_dropped");
        wr(9, 19, 7, 520, 1'b1, "wr_c9r19");
        render(560, 487, E_EDGE, "cell919_topleft");
        render(572, 499, E_PAL7, "cell919_interior");
        render(583, 510, E_EDGE, "cell919_botright");
        px(584, 499); expect_at(cyc + 2, K_RGB, E_GREY, "border_h584");

        pat = '{2'b10, 2'b01, 2'b00, 2'b11, 2'b01, 2'b10};
        for (int i = 0; i < 6; i++) begin
            px(0, 0);
            hsync = pat[i][1];
            vsync = pat[i][0];
            expect_at(cyc + 2, K_SYN, {6'd0, pat[i]}, "sync_delay");
        end
        px(0, 0);
        hsync = 1'b1;
        vsync = 1'b1;

        for (int v = 0; v <= 520; v++) begin
            px(0, v);
            expect_at(cyc + 1, K_FS, (v == 511) ? 8'd1 : 8'd0, "frame_start");
        end
        px(1, 511); expect_at(cyc + 1, K_FS, 8'd0, "frame_start_h1");

        // Holding clr pins the sweep at address 0, so the code-7 cell is
        // still in RAM while its pixels must render black.
        px(0, 200);
        bus.clr = 1'b1;
        expect_at(cyc, K_RDY, 8'd0, "clr_ready");
        render(572, 499, E_BLACK, "clear_black");
        expect_at(cyc, K_RDY, 8'd0, "clr_held_ready");
        @(posedge clk);
        #1;
        bus.clr = 1'b0;
        hcount  = 10'd0;
        vcount  = 10'd0;
        sweep_check(cyc, "clr_sweep");

        checks++;
        if (bus.wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL clr_sweep_ready_direct: got %b", bus.wr_ready);
        end

        render(356, 43, E_BLACK, "cleared_cell00");
        render(572, 499, E_BLACK, "cleared_cell919");

        px(0, 0);
        bus.clr = 1'b1;
        hsync   = 1'b0;
        cc      = cyc;
        expect_at(cyc, K_RDY, 8'd1, "pre_clr_ready");
        px(0, 0);
        bus.clr = 1'b0;
        expect_at(cyc, K_RDY, 8'd0, "mid_sweep_ready");
        for (int k = 0; k < 200 && (cyc - cc) < 101; k++) begin
            px(0, 0);
            expect_at(cyc, K_RDY, 8'd0, "mid_sweep_ready");
        end
        #1;
        rst = 1'b1;
        expect_at(cyc, K_SYN, 8'd3, "async_reset_sync");
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        hsync = 1'b1;
        sweep_check(cyc, "reset_restart_sweep");

        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        foreach (sb[i]) begin
            checks++;
            errors++;
            $display("FAIL %s: never compared, due cycle %0d now %0d", sb[i].name, sb[i].due, cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
